// File: rtl/seq_csa_multiplier.sv
// Iterative carry-save multiplier with valid/ready handshakes and a runtime signed/unsigned mode.
// Optional macro SEQ_CSA_MULT_EARLY_TERM_EN: leave RUN as soon as the remaining multiplier bits are zero.
module seq_csa_multiplier #(
  parameter int parallelism    = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       is_signed,
  input  logic [parallelism-1:0]     multiplier,
  input  logic [parallelism-1:0]     multiplicand,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*parallelism-1:0]   product
);

  localparam int W  = 2 * parallelism;
  localparam int N  = parallelism / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  if ((parallelism % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
    $error("seq_csa_multiplier: BITS_PER_CYCLE must divide parallelism");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [parallelism-1:0] mpr_q, mpr_d;
  logic [parallelism-1:0] mcand_q, mcand_d;
  logic [W-1:0]           sum_q, sum_d;
  logic [W-1:0]           carry_q, carry_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   neg_q, neg_d;
  logic [W-1:0]           product_q, product_d;
  logic                   out_valid_q, out_valid_d;
  logic                   in_ready_q, in_ready_d;

  logic [W-1:0]           step_sum_s, step_carry_s, resolved_s;

  // Magnitude of a two's-complement operand; the most negative value maps onto itself as unsigned.
  function automatic logic [parallelism-1:0] mag(input logic [parallelism-1:0] v, input logic sgn);
    if (sgn && v[parallelism-1]) begin
      mag = -v;
    end else begin
      mag = v;
    end
  endfunction

  // One RUN cycle: fold BITS_PER_CYCLE partial products into sum/carry through chained 3:2 compressors.
  always_comb begin
    step_sum_s   = sum_q;
    step_carry_s = carry_q;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      logic [W-1:0] pp, s_old, c_old;
      pp    = mpr_q[j] ? ({{parallelism{1'b0}}, mcand_q} << (int'(count_q) * BITS_PER_CYCLE + j))
                       : {W{1'b0}};
      s_old = step_sum_s;
      c_old = step_carry_s;
      step_sum_s   = s_old ^ c_old ^ pp;
      step_carry_s = ((s_old & c_old) | (s_old & pp) | (c_old & pp)) << 1;
    end
  end

  // Final carry-propagate add with optional sign restore.
  always_comb begin
    resolved_s = sum_q + carry_q;
    if (neg_q) begin
      resolved_s = -(sum_q + carry_q);
    end else begin
      resolved_s = sum_q + carry_q;
    end
  end

  // Next-state and datapath update for the handshake FSM.
  always_comb begin
    state_d     = state_q;
    mpr_d       = mpr_q;
    mcand_d     = mcand_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    count_d     = count_q;
    neg_d       = neg_q;
    product_d   = product_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mpr_d      = mag(multiplier, is_signed);
          mcand_d    = mag(multiplicand, is_signed);
          neg_d      = is_signed & (multiplier[parallelism-1] ^ multiplicand[parallelism-1]);
          sum_d      = {W{1'b0}};
          carry_d    = {W{1'b0}};
          count_d    = {CW{1'b0}};
          state_d    = RUN;
          in_ready_d = 1'b0;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      RUN: begin
`ifdef SEQ_CSA_MULT_EARLY_TERM_EN
        if (mpr_q == {parallelism{1'b0}}) begin
          state_d = RESOLVE;
        end else begin
          sum_d   = step_sum_s;
          carry_d = step_carry_s;
          mpr_d   = mpr_q >> BITS_PER_CYCLE;
          count_d = count_q + CW'(1);
          if (count_q == CW'(N - 1)) begin
            state_d = RESOLVE;
          end else begin
            state_d = RUN;
          end
        end
`else
        sum_d   = step_sum_s;
        carry_d = step_carry_s;
        mpr_d   = mpr_q >> BITS_PER_CYCLE;
        count_d = count_q + CW'(1);
        if (count_q == CW'(N - 1)) begin
          state_d = RESOLVE;
        end else begin
          state_d = RUN;
        end
`endif
      end
      RESOLVE: begin
        product_d   = resolved_s;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mpr_q       <= {parallelism{1'b0}};
      mcand_q     <= {parallelism{1'b0}};
      sum_q       <= {W{1'b0}};
      carry_q     <= {W{1'b0}};
      count_q     <= {CW{1'b0}};
      neg_q       <= 1'b0;
      product_q   <= {W{1'b0}};
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      mpr_q       <= mpr_d;
      mcand_q     <= mcand_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      count_q     <= count_d;
      neg_q       <= neg_d;
      product_q   <= product_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;

endmodule
